// File: rtl/enemy_run_animator.sv
// enemy_run_animator: one running enemy's spawn/motion/run-cycle/hit state plus a registered
// per-pixel sprite-box test that produces the sprite-local ROM address and frame select.
module enemy_run_animator #(
    parameter int SPRITE_W        = 40,
    parameter int SPRITE_H        = 66,
    parameter int GROUND_Y        = 300,
    parameter int SCREEN_W        = 640,
    parameter int SPEED           = 2,
    parameter int FRAMES_PER_STEP = 6,
    parameter int HIT_FRAMES      = 16
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        spawn,
    input  logic [9:0]  spawn_x,
    input  logic        spawn_dir,
    input  logic        kill,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        active,
    output logic [9:0]  sprite_x,
    output logic [1:0]  anim_frame,
    output logic        in_sprite,
    output logic [12:0] rom_address
);
    localparam int SW = $clog2(FRAMES_PER_STEP);
    localparam int HW = $clog2(HIT_FRAMES);
    localparam logic [9:0] X_MAX = 10'(SCREEN_W - SPRITE_W);

    typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

    state_t         state_q, state_d;
    logic [9:0]     x_q, x_d;
    logic [1:0]     frame_q, frame_d;
    logic [SW-1:0]  step_q, step_d;
    logic [HW-1:0]  hit_q, hit_d;
    logic           dir_q, dir_d;
    logic           in_q, in_d;
    logic [12:0]    rom_q, rom_d;
    logic [10:0]    x_sum;
    logic [9:0]     lx, ly;
    logic           box, step_wrap;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            frame_q <= '0;
            step_q  <= '0;
            hit_q   <= '0;
            dir_q   <= 1'b0;
            in_q    <= 1'b0;
            rom_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            frame_q <= frame_d;
            step_q  <= step_d;
            hit_q   <= hit_d;
            dir_q   <= dir_d;
            in_q    <= in_d;
            rom_q   <= rom_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        frame_d   = frame_q;
        step_d    = step_q;
        hit_d     = hit_q;
        dir_d     = dir_q;
        x_sum     = {1'b0, x_q} + 11'(SPEED);
        step_wrap = step_q == SW'(FRAMES_PER_STEP - 1);
        case (state_q)
            IDLE: if (spawn) begin
                state_d = RUN;
                x_d     = spawn_x > X_MAX ? X_MAX : spawn_x;
                dir_d   = spawn_dir;
                frame_d = '0;
                step_d  = '0;
            end
            RUN: if (kill) begin
                state_d = HIT;
                hit_d   = '0;
            end else if (frame_tick) begin
                if (dir_q) begin
                    if (x_sum > {1'b0, X_MAX}) state_d = IDLE;
                    else x_d = x_sum[9:0];
                end else begin
                    if (x_q < 10'(SPEED)) state_d = IDLE;
                    else x_d = x_q - 10'(SPEED);
                end
                step_d  = step_wrap ? '0 : step_q + SW'(1);
                frame_d = step_wrap ? frame_q + 2'd1 : frame_q;
            end
            HIT: if (frame_tick) begin
                hit_d = hit_q + HW'(1);
                if (hit_q == HW'(HIT_FRAMES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // ROM art faces left, so right-running enemies read columns mirrored
        box   = state_q != IDLE && {1'b0, DrawX} >= {1'b0, x_q}
                && {1'b0, DrawX} < {1'b0, x_q} + 11'(SPRITE_W)
                && DrawY >= 10'(GROUND_Y) && DrawY < 10'(GROUND_Y + SPRITE_H);
        lx    = dir_q ? 10'(SPRITE_W - 1) - (DrawX - x_q) : DrawX - x_q;
        ly    = DrawY - 10'(GROUND_Y);
        in_d  = box && !(state_q == HIT && hit_q[1]);
        rom_d = in_d ? 13'(ly) * 13'(SPRITE_W) + 13'(lx) : 13'd0;
    end

    assign active      = state_q != IDLE;
    assign sprite_x    = x_q;
    assign anim_frame  = frame_q;
    assign in_sprite   = in_q;
    assign rom_address = rom_q;
endmodule

// File: tb/tb_enemy_run_animator.sv
// tb_enemy_run_animator: directed corner sequences, a pixel vector table, and a randomized
// run checked against a tick-counting reference model of the enemy.
module tb_enemy_run_animator;
    logic        vga_clk = 1'b0;
    logic        reset = 1'b0, frame_tick = 1'b0, spawn = 1'b0, spawn_dir = 1'b0, kill = 1'b0;
    logic [9:0]  spawn_x = '0, DrawX = '0, DrawY = '0;
    logic        active, in_sprite;
    logic [9:0]  sprite_x;
    logic [1:0]  anim_frame;
    logic [12:0] rom_address;

    int total = 0, bad = 0;
    int m_state, m_x, m_dir, m_ticks, m_hit, m_in, m_rom;

    typedef struct {
        logic [9:0]  dx, dy;
        logic        exp_in;
        logic [12:0] exp_rom;
    } pix_vec_t;
    pix_vec_t vecs[8];

    enemy_run_animator dut (
        .vga_clk(vga_clk), .reset(reset), .frame_tick(frame_tick), .spawn(spawn),
        .spawn_x(spawn_x), .spawn_dir(spawn_dir), .kill(kill), .DrawX(DrawX), .DrawY(DrawY),
        .active(active), .sprite_x(sprite_x), .anim_frame(anim_frame),
        .in_sprite(in_sprite), .rom_address(rom_address)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic do_spawn(input int x, input logic d);
        spawn = 1'b1;
        spawn_x = 10'(x);
        spawn_dir = d;
        step();
        spawn = 1'b0;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic model_step();
        int lx;
        bit box, blink;
        box = m_state != 0 && int'(DrawX) >= m_x && int'(DrawX) < m_x + 40
              && int'(DrawY) >= 300 && int'(DrawY) < 366;
        blink = m_state == 2 && ((m_hit / 2) % 2 == 1);
        m_in = (box && !blink) ? 1 : 0;
        lx = m_dir ? 39 - (int'(DrawX) - m_x) : int'(DrawX) - m_x;
        m_rom = m_in ? (int'(DrawY) - 300) * 40 + lx : 0;
        if (reset) begin
            m_state = 0; m_x = 0; m_dir = 0; m_ticks = 0; m_hit = 0; m_in = 0; m_rom = 0;
        end else if (m_state == 0) begin
            if (spawn) begin
                m_state = 1;
                m_x = int'(spawn_x) > 600 ? 600 : int'(spawn_x);
                m_dir = int'(spawn_dir);
                m_ticks = 0;
            end
        end else if (m_state == 1) begin
            if (kill) begin
                m_state = 2;
                m_hit = 0;
            end else if (frame_tick) begin
                m_ticks++;
                if (m_dir == 0) begin
                    if (m_x < 2) m_state = 0; else m_x -= 2;
                end else begin
                    if (m_x + 2 > 600) m_state = 0; else m_x += 2;
                end
            end
        end else if (frame_tick) begin
            m_hit++;
            if (m_hit == 16) m_state = 0;
        end
    endtask

    initial begin
        vecs[0] = '{10'd100, 10'd300, 1'b1, 13'd0};
        vecs[1] = '{10'd139, 10'd365, 1'b1, 13'd2639};
        vecs[2] = '{10'd140, 10'd300, 1'b0, 13'd0};
        vecs[3] = '{10'd99,  10'd300, 1'b0, 13'd0};
        vecs[4] = '{10'd100, 10'd299, 1'b0, 13'd0};
        vecs[5] = '{10'd100, 10'd366, 1'b0, 13'd0};
        vecs[6] = '{10'd120, 10'd310, 1'b1, 13'd420};
        vecs[7] = '{10'd139, 10'd300, 1'b1, 13'd39};

        do_reset();
        chk("rst_active", int'(active), 0);
        chk("rst_x", int'(sprite_x), 0);
        chk("rst_anim", int'(anim_frame), 0);
        chk("rst_in", int'(in_sprite), 0);
        chk("rst_rom", int'(rom_address), 0);

        do_spawn(600, 1'b0);
        chk("spawn_active", int'(active), 1);
        for (int t = 1; t <= 24; t++) begin
            ticks(1);
            chk("run_anim", int'(anim_frame), (t / 6) % 4);
            if (t == 10) chk("run_x10", int'(sprite_x), 580);
        end
        chk("run_x24", int'(sprite_x), 552);

        do_reset();
        do_spawn(7, 1'b0);
        ticks(2);
        chk("left_x3", int'(sprite_x), 3);
        ticks(1);
        chk("left_x1", int'(sprite_x), 1);
        chk("left_alive", int'(active), 1);
        ticks(1);
        chk("left_gone", int'(active), 0);
        chk("left_hold", int'(sprite_x), 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("idle_kill", int'(active), 0);

        do_spawn(596, 1'b1);
        ticks(1);
        chk("right_598", int'(sprite_x), 598);
        ticks(1);
        chk("right_600", int'(sprite_x), 600);
        ticks(1);
        chk("right_gone", int'(active), 0);
        do_spawn(700, 1'b0);
        chk("clamp_x", int'(sprite_x), 600);
        do_reset();

        do_spawn(100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            DrawX = vecs[i].dx;
            DrawY = vecs[i].dy;
            step();
            chk($sformatf("pix%0d_in", i), int'(in_sprite), int'(vecs[i].exp_in));
            chk($sformatf("pix%0d_rom", i), int'(rom_address), int'(vecs[i].exp_rom));
        end
        do_reset();
        do_spawn(100, 1'b1);
        DrawX = 10'd100;
        DrawY = 10'd300;
        step();
        chk("mirror_rom", int'(rom_address), 39);

        DrawX = 10'd110;
        DrawY = 10'd310;
        kill = 1'b1;
        frame_tick = 1'b1;
        step();
        kill = 1'b0;
        frame_tick = 1'b0;
        chk("hit_active", int'(active), 1);
        chk("hit_x", int'(sprite_x), 100);
        step();
        chk("hit_in0", int'(in_sprite), 1);
        chk("hit_rom0", int'(rom_address), 429);
        for (int k = 1; k <= 16; k++) begin
            frame_tick = 1'b1;
            if (k == 5) begin spawn = 1'b1; spawn_x = 10'd10; end
            step();
            frame_tick = 1'b0;
            spawn = 1'b0;
            step();
            chk($sformatf("blink%0d", k), int'(in_sprite), (k < 16 && (k / 2) % 2 == 0) ? 1 : 0);
            chk($sformatf("hit_alive%0d", k), int'(active), k < 16 ? 1 : 0);
            chk($sformatf("hit_frozen%0d", k), int'(sprite_x), 100);
        end

        do_spawn(200, 1'b0);
        ticks(7);
        chk("pre_kill_x", int'(sprite_x), 186);
        chk("pre_kill_anim", int'(anim_frame), 1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        ticks(1);
        DrawX = 10'd190;
        DrawY = 10'd300;
        reset = 1'b1;
        spawn = 1'b1;
        frame_tick = 1'b1;
        step();
        reset = 1'b0;
        spawn = 1'b0;
        frame_tick = 1'b0;
        chk("midhit_active", int'(active), 0);
        chk("midhit_x", int'(sprite_x), 0);
        chk("midhit_anim", int'(anim_frame), 0);
        chk("midhit_in", int'(in_sprite), 0);
        chk("midhit_rom", int'(rom_address), 0);

        m_state = 0; m_x = 0; m_dir = 0; m_ticks = 0; m_hit = 0; m_in = 0; m_rom = 0;
        for (int i = 0; i < 6000; i++) begin
            reset      = $urandom_range(0, 599) == 0;
            frame_tick = $urandom_range(0, 3) == 0;
            spawn      = $urandom_range(0, 15) == 0;
            kill       = $urandom_range(0, 59) == 0;
            spawn_x    = 10'($urandom_range(0, 1023));
            spawn_dir  = 1'($urandom_range(0, 1));
            DrawX      = 10'((m_x + 1020 + int'($urandom_range(0, 50))) % 1024);
            DrawY      = 10'(295 + $urandom_range(0, 75));
            model_step();
            step();
            chk("rnd_active", int'(active), m_state != 0 ? 1 : 0);
            chk("rnd_x", int'(sprite_x), m_x);
            if (m_state != 0) chk("rnd_anim", int'(anim_frame), (m_ticks / 6) % 4);
            chk("rnd_in", int'(in_sprite), m_in);
            chk("rnd_rom", int'(rom_address), m_rom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
